ex_flag_stage: RTL

//  Registered back end of the EX stage. Sits directly downstream of the 16-bit add/sub/padd unit and the logic unit.

---
 rtl/ex_flag_stage_pkg.sv | 25 ++
 rtl/ex_flag_stage_branch_cond_eval.sv | 35 +++
 rtl/ex_flag_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ex_flag_stage_pkg.sv
// ============================================================================
//  Module   : ex_flag_stage_pkg
//  Purpose  : Shared widths and branch condition codes for the EX back end
//             and the ID-stage early-branch logic.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_flag_stage_pkg;

    localparam int DW_DEFAULT  = 16;
    localparam int CCW_DEFAULT = 3;

    localparam logic [2:0] CCC_NEQ    = 3'b000;
    localparam logic [2:0] CCC_EQ     = 3'b001;
    localparam logic [2:0] CCC_GT     = 3'b010;
    localparam logic [2:0] CCC_LT     = 3'b011;
    localparam logic [2:0] CCC_GTE    = 3'b100;
    localparam logic [2:0] CCC_LTE    = 3'b101;
    localparam logic [2:0] CCC_OVFL   = 3'b110;
    localparam logic [2:0] CCC_UNCOND = 3'b111;

endpackage

`default_nettype wire

// File: rtl/ex_flag_stage_branch_cond_eval.sv
// ============================================================================
//  Module   : branch_cond_eval
//  Purpose  : Combinational decode of a branch condition code against Z/V/N.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_cond_eval
    import ex_flag_stage_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CCC_NEQ:    taken = !z;
            CCC_EQ:     taken = z;
            CCC_GT:     taken = !z && !n;
            CCC_LT:     taken = n;
            CCC_GTE:    taken = z || !n;
            CCC_LTE:    taken = n || z;
            CCC_OVFL:   taken = v;
            CCC_UNCOND: taken = 1'b1;
            default:    taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ex_flag_stage.sv
// ============================================================================
//  Module   : ex_flag_stage
//  Purpose  : EX/MEM pipeline register, Z/V/N flag register with same-cycle
//             bypass, and registered branch resolution.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_flag_stage
    import ex_flag_stage_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int CCW = CCW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   ex_result,
    input  logic            ex_v,
    input  logic            ex_n,
    input  logic            ex_valid,
    input  logic            we_z,
    input  logic            we_vn,
    input  logic            stall,
    input  logic            flush,
    input  logic            br_req,
    input  logic [CCW-1:0]  br_ccc,
    output logic [DW-1:0]   mem_result,
    output logic            mem_valid,
    output logic            flag_z,
    output logic            flag_v,
    output logic            flag_n,
    output logic            br_taken,
    output logic            br_done
);

    logic [DW-1:0] mem_result_q, mem_result_d;
    logic          mem_valid_q,  mem_valid_d;
    logic          flag_z_q,     flag_z_d;
    logic          flag_v_q,     flag_v_d;
    logic          flag_n_q,     flag_n_d;
    logic          br_taken_q,   br_taken_d;
    logic          br_done_q,    br_done_d;

    logic w_z_new;
    logic w_wr_z;
    logic w_wr_vn;
    logic w_eff_z;
    logic w_eff_v;
    logic w_eff_n;
    logic w_cond;

    assign w_z_new = (ex_result == '0);
    assign w_wr_z  = ex_valid & we_z;
    assign w_wr_vn = ex_valid & we_vn;

    // A branch resolving alongside a flag-writing instruction sees the new flags.
    assign w_eff_z = w_wr_z  ? w_z_new : flag_z_q;
    assign w_eff_v = w_wr_vn ? ex_v    : flag_v_q;
    assign w_eff_n = w_wr_vn ? ex_n    : flag_n_q;

    branch_cond_eval u_cond (
        .ccc   (br_ccc[2:0]),
        .z     (w_eff_z),
        .v     (w_eff_v),
        .n     (w_eff_n),
        .taken (w_cond)
    );

    always_comb begin
        mem_result_d = mem_result_q;
        mem_valid_d  = mem_valid_q;
        flag_z_d     = flag_z_q;
        flag_v_d     = flag_v_q;
        flag_n_d     = flag_n_q;
        br_taken_d   = br_taken_q;
        br_done_d    = br_done_q;
        if (flush) begin
            mem_result_d = '0;
            mem_valid_d  = 1'b0;
            br_taken_d   = 1'b0;
            br_done_d    = 1'b0;
        end else if (!stall) begin
            mem_result_d = ex_result;
            mem_valid_d  = ex_valid;
            flag_z_d     = w_eff_z;
            flag_v_d     = w_eff_v;
            flag_n_d     = w_eff_n;
            br_taken_d   = br_req & w_cond;
            br_done_d    = br_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_result_q <= '0;
            mem_valid_q  <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_v_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            br_taken_q   <= 1'b0;
            br_done_q    <= 1'b0;
        end else begin
            mem_result_q <= mem_result_d;
            mem_valid_q  <= mem_valid_d;
            flag_z_q     <= flag_z_d;
            flag_v_q     <= flag_v_d;
            flag_n_q     <= flag_n_d;
            br_taken_q   <= br_taken_d;
            br_done_q    <= br_done_d;
        end
    end

    assign mem_result = mem_result_q;
    assign mem_valid  = mem_valid_q;
    assign flag_z     = flag_z_q;
    assign flag_v     = flag_v_q;
    assign flag_n     = flag_n_q;
    assign br_taken   = br_taken_q;
    assign br_done    = br_done_q;

endmodule

`default_nettype wire
